// File: rtl/clock_pkg.sv
// Shared time-of-day widths, wrap limits and the alarm sequencer state type.
package clock_pkg;

    localparam int MIN_W            = 6;
    localparam int HOUR_W           = 5;
    localparam int MINUTES_PER_HOUR = 60;
    localparam int HOURS_PER_DAY    = 24;

    typedef enum logic [1:0] {
        ALM_IDLE    = 2'd0,
        ALM_RINGING = 2'd1,
        ALM_SNOOZED = 2'd2
    } alarm_state_t;

endpackage

// File: rtl/time_offset_adder.sv
// Combinational hh:mm + minute-offset adder that wraps at 60 minutes and 24 hours.
module time_offset_adder
    import clock_pkg::*;
(
    input  logic [HOUR_W-1:0] hours_in,
    input  logic [MIN_W-1:0]  minutes_in,
    input  logic [MIN_W-1:0]  offset_minutes,
    output logic [HOUR_W-1:0] hours_out,
    output logic [MIN_W-1:0]  minutes_out
);

    localparam logic [MIN_W:0]  MIN_WRAP  = (MIN_W+1)'(MINUTES_PER_HOUR);
    localparam logic [HOUR_W:0] HOUR_WRAP = (HOUR_W+1)'(HOURS_PER_DAY);

    logic [MIN_W:0]  min_sum;
    logic            min_carry;
    logic [HOUR_W:0] hour_sum;

    // One extra bit on each sum so a carry is never lost before the wrap test.
    assign min_sum     = {1'b0, minutes_in} + {1'b0, offset_minutes};
    assign min_carry   = (min_sum >= MIN_WRAP);
    assign minutes_out = min_carry ? MIN_W'(min_sum - MIN_WRAP) : min_sum[MIN_W-1:0];

    assign hour_sum    = {1'b0, hours_in} + {{HOUR_W{1'b0}}, min_carry};
    assign hours_out   = (hour_sum >= HOUR_WRAP) ? HOUR_W'(hour_sum - HOUR_WRAP)
                                                 : hour_sum[HOUR_W-1:0];

endmodule

// File: rtl/alarm_snooze_controller.sv
// Alarm sequencer: starts a ring on an alarm-time rise, times it out, and
// re-rings after a bounded number of snoozes.
module alarm_snooze_controller
    import clock_pkg::*;
#(
    parameter int RING_MINUTES   = 5,
    parameter int SNOOZE_MINUTES = 9,
    parameter int MAX_SNOOZES    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              minute_tick,
    input  logic [MIN_W-1:0]  curr_minutes,
    input  logic [HOUR_W-1:0] curr_hours,
    input  logic [MIN_W-1:0]  alarm_minutes,
    input  logic [HOUR_W-1:0] alarm_hours,
    input  logic              alarm_enable,
    input  logic              set_alarm,
    input  logic              set_time,
    input  logic              snooze_btn,
    input  logic              dismiss_btn,
    output logic              alarm_trigger,
    output logic              snoozed,
    output logic [2:0]        snooze_count,
    output logic [MIN_W-1:0]  next_ring_minutes,
    output logic [HOUR_W-1:0] next_ring_hours,
    output logic [1:0]        state
);

    localparam logic [3:0]       RING_LAST     = 4'(RING_MINUTES - 1);
    localparam logic [2:0]       MAX_CNT       = 3'(MAX_SNOOZES);
    localparam logic [MIN_W-1:0] SNOOZE_OFFSET = MIN_W'(SNOOZE_MINUTES);

    alarm_state_t      state_q, state_d;
    logic [3:0]        ring_cnt_q, ring_cnt_d;
    logic [2:0]        count_d;
    logic [MIN_W-1:0]  nr_min_d, snz_minutes;
    logic [HOUR_W-1:0] nr_hour_d, snz_hours;

    logic match, match_prev, snz_match, snz_match_prev;
    logic snooze_prev, dismiss_prev;
    logic match_rise, snz_rise, snooze_rise, dismiss_rise;

    assign match     = alarm_enable && (curr_minutes == alarm_minutes) && (curr_hours == alarm_hours);
    assign snz_match = (curr_minutes == next_ring_minutes) && (curr_hours == next_ring_hours);

    // Rise detection keeps a minute-long match or a held button to a single action.
    assign match_rise   = match && !match_prev;
    assign snz_rise     = snz_match && !snz_match_prev;
    assign snooze_rise  = snooze_btn && !snooze_prev;
    assign dismiss_rise = dismiss_btn && !dismiss_prev;

    assign state = state_q;

    time_offset_adder u_snooze_adder (
        .hours_in       (curr_hours),
        .minutes_in     (curr_minutes),
        .offset_minutes (SNOOZE_OFFSET),
        .hours_out      (snz_hours),
        .minutes_out    (snz_minutes)
    );

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        count_d    = snooze_count;
        nr_min_d   = next_ring_minutes;
        nr_hour_d  = next_ring_hours;

        if (set_alarm || !alarm_enable) begin
            state_d = ALM_IDLE;
        end else if (set_time && state_q != ALM_IDLE) begin
            state_d = ALM_IDLE;
        end else begin
            case (state_q)
                ALM_IDLE: begin
                    if (match_rise) begin
                        state_d    = ALM_RINGING;
                        ring_cnt_d = '0;
                        count_d    = '0;
                    end
                end
                ALM_RINGING: begin
                    if (dismiss_rise) begin
                        state_d = ALM_IDLE;
                    end else if (minute_tick && ring_cnt_q == RING_LAST) begin
                        state_d = ALM_IDLE;
                    end else begin
                        if (minute_tick) ring_cnt_d = ring_cnt_q + 4'd1;
                        if (snooze_rise && snooze_count < MAX_CNT) begin
                            state_d   = ALM_SNOOZED;
                            count_d   = snooze_count + 3'd1;
                            nr_min_d  = snz_minutes;
                            nr_hour_d = snz_hours;
                        end
                    end
                end
                ALM_SNOOZED: begin
                    if (dismiss_rise) begin
                        state_d = ALM_IDLE;
                    end else if (snz_rise) begin
                        state_d    = ALM_RINGING;
                        ring_cnt_d = '0;
                    end
                end
                default: state_d = ALM_IDLE;
            endcase
        end

        // Any exit to IDLE ends the alarm event; the snooze target is kept.
        if (state_d == ALM_IDLE) begin
            ring_cnt_d = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= ALM_IDLE;
            ring_cnt_q        <= '0;
            snooze_count      <= '0;
            next_ring_minutes <= '0;
            next_ring_hours   <= '0;
            alarm_trigger     <= 1'b0;
            snoozed           <= 1'b0;
            match_prev        <= 1'b0;
            snz_match_prev    <= 1'b0;
            snooze_prev       <= 1'b0;
            dismiss_prev      <= 1'b0;
        end else begin
            state_q           <= state_d;
            ring_cnt_q        <= ring_cnt_d;
            snooze_count      <= count_d;
            next_ring_minutes <= nr_min_d;
            next_ring_hours   <= nr_hour_d;
            alarm_trigger     <= (state_d == ALM_RINGING);
            snoozed           <= (state_d == ALM_SNOOZED);
            match_prev        <= match;
            snz_match_prev    <= snz_match;
            snooze_prev       <= snooze_btn;
            dismiss_prev      <= dismiss_btn;
        end
    end

endmodule

// File: tb/tb_alarm_snooze_controller.sv
// Bench for alarm_snooze_controller: vector table of inputs and hand-derived
// outputs, driven one clock per row, plus an asynchronous-reset sequence.
module tb_alarm_snooze_controller;

    localparam int W    = 18;
    localparam int ST_I = 0;
    localparam int ST_R = 1;
    localparam int ST_S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       minute_tick;
    logic [5:0] curr_minutes, alarm_minutes;
    logic [4:0] curr_hours, alarm_hours;
    logic       alarm_enable, set_alarm, set_time, snooze_btn, dismiss_btn;
    logic       alarm_trigger, snoozed;
    logic [2:0] snooze_count;
    logic [5:0] next_ring_minutes;
    logic [4:0] next_ring_hours;
    logic [1:0] state;

    typedef struct {
        logic       tick;
        logic [4:0] ch;
        logic [5:0] cm;
        logic [4:0] ah;
        logic [5:0] am;
        logic       en, sa, stm, sz, ds;
        logic [W-1:0] exp;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;

    alarm_snooze_controller dut (
        .clk               (clk),
        .rst               (rst),
        .minute_tick       (minute_tick),
        .curr_minutes      (curr_minutes),
        .curr_hours        (curr_hours),
        .alarm_minutes     (alarm_minutes),
        .alarm_hours       (alarm_hours),
        .alarm_enable      (alarm_enable),
        .set_alarm         (set_alarm),
        .set_time          (set_time),
        .snooze_btn        (snooze_btn),
        .dismiss_btn       (dismiss_btn),
        .alarm_trigger     (alarm_trigger),
        .snoozed           (snoozed),
        .snooze_count      (snooze_count),
        .next_ring_minutes (next_ring_minutes),
        .next_ring_hours   (next_ring_hours),
        .state             (state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Expected word layout: {trigger, snoozed, count[2:0], hours[4:0], minutes[5:0], state[1:0]}.
    function automatic vec_t mk(input int tk, input int ch, input int cm, input int ah, input int am,
                                input int en, input int sa, input int stm, input int sz, input int ds,
                                input int e_tr, input int e_sd, input int e_cnt, input int e_nh,
                                input int e_nm, input int e_st);
        vec_t v;
        v.tick = 1'(tk);  v.ch = 5'(ch);  v.cm = 6'(cm);  v.ah = 5'(ah);  v.am = 6'(am);
        v.en = 1'(en);  v.sa = 1'(sa);  v.stm = 1'(stm);  v.sz = 1'(sz);  v.ds = 1'(ds);
        v.exp = {1'(e_tr), 1'(e_sd), 3'(e_cnt), 5'(e_nh), 6'(e_nm), 2'(e_st)};
        return v;
    endfunction

    task automatic check_out(input string name);
        logic [W-1:0] e, a;
        e = exp_q.pop_front();
        a = {alarm_trigger, snoozed, snooze_count, next_ring_hours, next_ring_minutes, state};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got trig=%0d snoozed=%0d count=%0d next=%0d:%0d state=%0d, expected trig=%0d snoozed=%0d count=%0d next=%0d:%0d state=%0d",
                     name, a[17], a[16], a[15:13], a[12:8], a[7:2], a[1:0],
                     e[17], e[16], e[15:13], e[12:8], e[7:2], e[1:0]);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        minute_tick   = v.tick;
        curr_hours    = v.ch;
        curr_minutes  = v.cm;
        alarm_hours   = v.ah;
        alarm_minutes = v.am;
        alarm_enable  = v.en;
        set_alarm     = v.sa;
        set_time      = v.stm;
        snooze_btn    = v.sz;
        dismiss_btn   = v.ds;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    initial begin
        // Alarm 07:30: ring, five-tick timeout, no re-trigger while still 07:30
        vecs.push_back(mk(0, 7,29, 7,30, 1,0,0,0,0, 0,0,0, 0, 0,ST_I));
        vecs.push_back(mk(0, 7,30, 7,30, 1,0,0,0,0, 1,0,0, 0, 0,ST_R));
        vecs.push_back(mk(1, 7,30, 7,30, 1,0,0,0,0, 1,0,0, 0, 0,ST_R));
        vecs.push_back(mk(0, 7,30, 7,30, 1,0,0,0,0, 1,0,0, 0, 0,ST_R));
        vecs.push_back(mk(1, 7,30, 7,30, 1,0,0,0,0, 1,0,0, 0, 0,ST_R));
        vecs.push_back(mk(1, 7,30, 7,30, 1,0,0,0,0, 1,0,0, 0, 0,ST_R));
        vecs.push_back(mk(1, 7,30, 7,30, 1,0,0,0,0, 1,0,0, 0, 0,ST_R));
        vecs.push_back(mk(1, 7,30, 7,30, 1,0,0,0,0, 0,0,0, 0, 0,ST_I));
        vecs.push_back(mk(0, 7,30, 7,30, 1,0,0,0,0, 0,0,0, 0, 0,ST_I));
        vecs.push_back(mk(0, 7,30, 7,30, 1,0,0,0,0, 0,0,0, 0, 0,ST_I));
        vecs.push_back(mk(1, 7,31, 7,30, 1,0,0,0,0, 0,0,0, 0, 0,ST_I));
        // Snooze across midnight: 23:55 + 9 -> 00:04, re-ring there, then dismiss
        vecs.push_back(mk(0,23,54,23,55, 1,1,0,0,0, 0,0,0, 0, 0,ST_I));
        vecs.push_back(mk(0,23,55,23,55, 1,0,0,0,0, 1,0,0, 0, 0,ST_R));
        vecs.push_back(mk(0,23,55,23,55, 1,0,0,1,0, 0,1,1, 0, 4,ST_S));
        vecs.push_back(mk(0,23,55,23,55, 1,0,0,0,0, 0,1,1, 0, 4,ST_S));
        vecs.push_back(mk(1,23,56,23,55, 1,0,0,0,0, 0,1,1, 0, 4,ST_S));
        vecs.push_back(mk(0, 0, 4,23,55, 1,0,0,0,0, 1,0,1, 0, 4,ST_R));
        vecs.push_back(mk(0, 0, 4,23,55, 1,0,0,0,1, 0,0,0, 0, 4,ST_I));
        vecs.push_back(mk(0, 0, 4,23,55, 1,0,0,0,0, 0,0,0, 0, 4,ST_I));
        // 10:58 + 9 -> 11:07, dismissed while snoozed, nothing at 11:07
        vecs.push_back(mk(0,10,57,10,58, 1,1,0,0,0, 0,0,0, 0, 4,ST_I));
        vecs.push_back(mk(0,10,58,10,58, 1,0,0,0,0, 1,0,0, 0, 4,ST_R));
        vecs.push_back(mk(0,10,58,10,58, 1,0,0,1,0, 0,1,1,11, 7,ST_S));
        vecs.push_back(mk(0,10,58,10,58, 1,0,0,0,1, 0,0,0,11, 7,ST_I));
        vecs.push_back(mk(0,11, 7,10,58, 1,0,0,0,0, 0,0,0,11, 7,ST_I));
        vecs.push_back(mk(1,11, 7,10,58, 1,0,0,0,0, 0,0,0,11, 7,ST_I));
        // Three snoozes, fourth ignored, ring still times out
        vecs.push_back(mk(0, 5,59, 6, 0, 1,1,0,0,0, 0,0,0,11, 7,ST_I));
        vecs.push_back(mk(0, 6, 0, 6, 0, 1,0,0,0,0, 1,0,0,11, 7,ST_R));
        vecs.push_back(mk(0, 6, 0, 6, 0, 1,0,0,1,0, 0,1,1, 6, 9,ST_S));
        vecs.push_back(mk(0, 6, 9, 6, 0, 1,0,0,0,0, 1,0,1, 6, 9,ST_R));
        vecs.push_back(mk(0, 6, 9, 6, 0, 1,0,0,1,0, 0,1,2, 6,18,ST_S));
        vecs.push_back(mk(0, 6,10, 6, 0, 1,0,0,0,0, 0,1,2, 6,18,ST_S));
        vecs.push_back(mk(0, 6,18, 6, 0, 1,0,0,0,0, 1,0,2, 6,18,ST_R));
        vecs.push_back(mk(0, 6,18, 6, 0, 1,0,0,1,0, 0,1,3, 6,27,ST_S));
        vecs.push_back(mk(0, 6,19, 6, 0, 1,0,0,0,0, 0,1,3, 6,27,ST_S));
        vecs.push_back(mk(0, 6,27, 6, 0, 1,0,0,0,0, 1,0,3, 6,27,ST_R));
        vecs.push_back(mk(0, 6,27, 6, 0, 1,0,0,1,0, 1,0,3, 6,27,ST_R));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1, 6,27, 6, 0, 1,0,0,0,0, 1,0,3, 6,27,ST_R));
        vecs.push_back(mk(1, 6,27, 6, 0, 1,0,0,0,0, 0,0,0, 6,27,ST_I));
        // Snooze and dismiss together: dismiss wins
        vecs.push_back(mk(0, 8,14, 8,15, 1,1,0,0,0, 0,0,0, 6,27,ST_I));
        vecs.push_back(mk(0, 8,15, 8,15, 1,0,0,0,0, 1,0,0, 6,27,ST_R));
        vecs.push_back(mk(0, 8,15, 8,15, 1,0,0,1,1, 0,0,0, 6,27,ST_I));
        vecs.push_back(mk(0, 8,15, 8,15, 1,0,0,0,0, 0,0,0, 6,27,ST_I));
        // Held snooze across a re-ring counts once; snooze on timeout tick loses
        vecs.push_back(mk(0, 8,59, 9, 0, 1,1,0,0,0, 0,0,0, 6,27,ST_I));
        vecs.push_back(mk(0, 9, 0, 9, 0, 1,0,0,0,0, 1,0,0, 6,27,ST_R));
        vecs.push_back(mk(0, 9, 0, 9, 0, 1,0,0,1,0, 0,1,1, 9, 9,ST_S));
        vecs.push_back(mk(0, 9, 9, 9, 0, 1,0,0,1,0, 1,0,1, 9, 9,ST_R));
        vecs.push_back(mk(0, 9, 9, 9, 0, 1,0,0,1,0, 1,0,1, 9, 9,ST_R));
        vecs.push_back(mk(0, 9, 9, 9, 0, 1,0,0,0,0, 1,0,1, 9, 9,ST_R));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1, 9, 9, 9, 0, 1,0,0,0,0, 1,0,1, 9, 9,ST_R));
        vecs.push_back(mk(1, 9, 9, 9, 0, 1,0,0,1,0, 0,0,0, 9, 9,ST_I));
        vecs.push_back(mk(0, 9, 9, 9, 0, 1,0,0,0,0, 0,0,0, 9, 9,ST_I));
        // set_alarm while ringing, set_time while snoozed, enable dropped
        vecs.push_back(mk(0,11,59,12, 0, 1,1,0,0,0, 0,0,0, 9, 9,ST_I));
        vecs.push_back(mk(0,12, 0,12, 0, 1,0,0,0,0, 1,0,0, 9, 9,ST_R));
        vecs.push_back(mk(0,12, 0,12, 0, 1,1,0,0,0, 0,0,0, 9, 9,ST_I));
        vecs.push_back(mk(0,12, 0,12, 0, 1,0,0,0,0, 0,0,0, 9, 9,ST_I));
        vecs.push_back(mk(0,12,59,13, 0, 1,1,0,0,0, 0,0,0, 9, 9,ST_I));
        vecs.push_back(mk(0,13, 0,13, 0, 1,0,0,0,0, 1,0,0, 9, 9,ST_R));
        vecs.push_back(mk(0,13, 0,13, 0, 1,0,0,1,0, 0,1,1,13, 9,ST_S));
        vecs.push_back(mk(0,13, 0,13, 0, 1,0,1,0,0, 0,0,0,13, 9,ST_I));
        vecs.push_back(mk(0,13,59,14, 0, 1,1,0,0,0, 0,0,0,13, 9,ST_I));
        vecs.push_back(mk(0,14, 0,14, 0, 1,0,0,0,0, 1,0,0,13, 9,ST_R));
        vecs.push_back(mk(0,14, 0,14, 0, 0,0,0,0,0, 0,0,0,13, 9,ST_I));
        vecs.push_back(mk(0,14, 0,14, 0, 1,0,0,0,0, 1,0,0,13, 9,ST_R));
        vecs.push_back(mk(0,14, 0,14, 0, 1,0,0,0,1, 0,0,0,13, 9,ST_I));

        // Clock/reset
        rst = 1'b1;
        minute_tick = 1'b0;  curr_hours = 5'd0;  curr_minutes = 6'd0;
        alarm_hours = 5'd0;  alarm_minutes = 6'd0;  alarm_enable = 1'b0;
        set_alarm = 1'b0;  set_time = 1'b0;  snooze_btn = 1'b0;  dismiss_btn = 1'b0;
        #2 rst = 1'b0;
        exp_q.push_back('0);
        #2 check_out("reset_values");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a ring
        run_vec(mk(0,14,59,15, 0, 1,1,0,0,0, 0,0,0,13, 9,ST_I), "rst_seq_load");
        run_vec(mk(0,15, 0,15, 0, 1,0,0,0,0, 1,0,0,13, 9,ST_R), "rst_seq_ring");
        run_vec(mk(1,15, 0,15, 0, 1,0,0,0,0, 1,0,0,13, 9,ST_R), "rst_seq_tick");
        minute_tick  = 1'b0;
        curr_minutes = 6'd1;
        rst          = 1'b0;
        exp_q.push_back('0);
        #2 check_out("async_reset_mid_ring");
        @(posedge clk);
        #1 rst = 1'b1;
        run_vec(mk(0,15, 1,15, 0, 1,0,0,0,0, 0,0,0, 0, 0,ST_I), "after_rst_idle");
        run_vec(mk(0,15, 0,15, 0, 1,0,0,0,0, 1,0,0, 0, 0,ST_R), "after_rst_new_match");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
